// File: rtl/jk_cnt_pkg.sv
// jk_cnt_pkg: definitions shared by the JK-cell counter.
//   - JK input codes (J,K) for hold/clear/set/toggle
//   - default WIDTH/MODULUS for the counter
//   - jk_excite(): toggle-form excitation for one bit, given current and next state
package jk_cnt_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    localparam int unsigned DEF_WIDTH   = 4;
    localparam int unsigned DEF_MODULUS = 10;

    // Toggle form: a changing bit gets J=K=1, a steady bit gets J=K=0.
    function automatic logic [1:0] jk_excite(input logic cur, input logic nxt);
        return (cur ^ nxt) ? JK_TGL : JK_HOLD;
    endfunction

endpackage

// File: rtl/jk_counter_ctrl_if.sv
// jk_counter_ctrl_if: control/status bundle of the JK counter.
//   EN, UP, LOAD, D     : count enable, direction, parallel load, load value (master -> slave)
//   Q, J, K             : count and per-cell excitation (slave -> master)
//   TC, WRAP, LOAD_ERR  : terminal count, wrap pulse, out-of-range load pulse (slave -> master)
interface jk_counter_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic             EN;
    logic             UP;
    logic             LOAD;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] J;
    logic [WIDTH-1:0] K;
    logic             TC;
    logic             WRAP;
    logic             LOAD_ERR;

    modport master (
        output EN, UP, LOAD, D,
        input  Q, J, K, TC, WRAP, LOAD_ERR
    );

    modport slave (
        input  EN, UP, LOAD, D,
        output Q, J, K, TC, WRAP, LOAD_ERR
    );
endinterface

// File: rtl/jk_counter_ctrl_cell.sv
// jk_cell: a single JK storage bit.
//   CLK : clock, updates on posedge
//   RST : synchronous reset to 0, active-high
//   J,K : 00 hold, 01 clear, 10 set, 11 toggle
//   Q   : stored bit
module jk_cell
    import jk_cnt_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic J,
    input  logic K,
    output logic Q
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            Q <= 1'b0;
        end else begin
            case ({J, K})
                JK_HOLD: Q <= Q;
                JK_CLR:  Q <= 1'b0;
                JK_SET:  Q <= 1'b1;
                default: Q <= ~Q;
            endcase
        end
    end

endmodule

// File: rtl/jk_counter_ctrl.sv
// jk_counter_ctrl: modulo up/down counter whose state lives in WIDTH JK cells.
// The next count is computed here and turned into toggle-form J/K for the cells.
//   CLK, RST : clock and synchronous active-high reset
//   bus      : jk_counter_ctrl_if.slave (EN, UP, LOAD, D in; Q, J, K, TC, WRAP, LOAD_ERR out)
// Parameters: WIDTH (cells), MODULUS (count range 0..MODULUS-1, 2..2**WIDTH).
// Build option: define JK_CNT_SATURATE_EN to saturate at the ends instead of wrapping.
module jk_counter_ctrl
    import jk_cnt_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned MODULUS = DEF_MODULUS
) (
    input  logic               CLK,
    input  logic               RST,
    jk_counter_ctrl_if.slave   bus
);

    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("jk_counter_ctrl: MODULUS out of range for WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             term;
    logic             tc;
    logic             wrap_now;
    logic             load_bad;
    logic             wrap_q;
    logic             load_err_q;

    always_comb begin
        nxt      = q;
        wrap_now = 1'b0;
        load_bad = 1'b0;
        term     = bus.UP ? (q == MAX) : (q == '0);
        tc       = ~RST & bus.EN & ~bus.LOAD & term;
        if (RST) begin
            // Next state 0 makes every set bit toggle and every clear bit hold.
            nxt = '0;
        end else if (bus.LOAD) begin
            if (64'(bus.D) < 64'(MODULUS)) begin
                nxt = bus.D;
            end else begin
                nxt      = MAX;
                load_bad = 1'b1;
            end
        end else if (bus.EN) begin
            if (term) begin
`ifdef JK_CNT_SATURATE_EN
                nxt = q;
`else
                nxt      = bus.UP ? '0 : MAX;
                wrap_now = 1'b1;
`endif
            end else begin
                nxt = bus.UP ? q + 1'b1 : q - 1'b1;
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign {j[i], k[i]} = jk_excite(q[i], nxt[i]);

        jk_cell u_cell (
            .CLK (CLK),
            .RST (RST),
            .J   (j[i]),
            .K   (k[i]),
            .Q   (q[i])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            wrap_q     <= wrap_now;
            load_err_q <= load_bad;
        end
    end

    assign bus.Q        = q;
    assign bus.J        = j;
    assign bus.K        = k;
    assign bus.TC       = tc;
    assign bus.WRAP     = wrap_q;
    assign bus.LOAD_ERR = load_err_q;

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// Self-checking bench for jk_counter_ctrl (WIDTH=4, MODULUS=10).
// Directed vector table plus randomized stimulus against an arithmetic reference model.
module tb_jk_counter_ctrl;

    localparam int W = 4;
    localparam int M = 10;

`ifdef JK_CNT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST;

    jk_counter_ctrl_if #(.WIDTH(W)) bus ();

    jk_counter_ctrl #(.WIDTH(W), .MODULUS(M)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_q    = 0;
    int m_wrap = 0;
    int m_lerr = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic       up;
        logic       load;
        logic [3:0] d;
        int         q;
        int         wrap;
        int         lerr;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive, check combinational outputs against the model, clock, check registers.
    task automatic step(input logic rst, input logic en, input logic up,
                        input logic load, input logic [3:0] d);
        int n, w, le, tc, term;
        @(negedge CLK);
        RST = rst; bus.EN = en; bus.UP = up; bus.LOAD = load; bus.D = d;
        #1;
        n = m_q; w = 0; le = 0; tc = 0;
        term = up ? (m_q == M - 1) : (m_q == 0);
        if (rst) begin
            n = 0;
        end else if (load) begin
            if (int'(d) < M) n = int'(d);
            else begin n = M - 1; le = 1; end
        end else if (en) begin
            tc = term;
            if (term && SAT) n = m_q;
            else n = up ? (m_q + 1) % M : (m_q + M - 1) % M;
            w = (term && !SAT) ? 1 : 0;
        end
        chk("J", int'(bus.J), m_q ^ n);
        chk("K", int'(bus.K), m_q ^ n);
        chk("TC", int'(bus.TC), tc);
        @(posedge CLK);
        #1;
        m_q = n; m_wrap = w; m_lerr = le;
        chk("Q", int'(bus.Q), m_q);
        chk("WRAP", int'(bus.WRAP), m_wrap);
        chk("LOAD_ERR", int'(bus.LOAD_ERR), m_lerr);
    endtask

    function automatic void add(input logic rst, input logic en, input logic up,
                                input logic load, input logic [3:0] d,
                                input int q, input int wrap, input int lerr);
        vec_t v;
        v.rst = rst; v.en = en; v.up = up; v.load = load; v.d = d;
        v.q = q; v.wrap = wrap; v.lerr = lerr;
        tbl.push_back(v);
    endfunction

    initial begin
        RST = 1'b1; bus.EN = 1'b0; bus.UP = 1'b1; bus.LOAD = 1'b0; bus.D = '0;

        // Reset held for two cycles with EN=1
        add(1, 1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0);
`ifndef JK_CNT_SATURATE_EN
        // Count 1..9, wrap to 0, then 1, 2
        for (int i = 1; i <= 12; i++)
            add(0, 1, 1, 0, 0, i % 10, (i == 10) ? 1 : 0, 0);
        // Down wrap from 0
        add(0, 0, 1, 1, 4'd0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 9, 1, 0);
        add(0, 1, 0, 0, 0, 8, 0, 0);
        add(0, 1, 0, 0, 0, 7, 0, 0);
`endif
        // Out-of-range load clamps to 9 with a one-cycle error pulse
        add(0, 0, 1, 1, 4'd13, 9, 0, 1);
        add(0, 0, 1, 0, 0, 9, 0, 0);
        // Load wins over enable at terminal count: no wrap
        add(0, 1, 1, 1, 4'd5, 5, 0, 0);
        // 7 -> 8 toggles every bit; then hold for five cycles
        add(0, 0, 1, 1, 4'd7, 7, 0, 0);
        add(0, 1, 1, 0, 0, 8, 0, 0);
        for (int i = 0; i < 5; i++)
            add(0, 0, 1, 0, 0, 8, 0, 0);
        // Reset mid-count, then resume
        add(0, 0, 1, 1, 4'd6, 6, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 1, 0, 0);
        add(0, 1, 1, 0, 0, 2, 0, 0);
`ifdef JK_CNT_SATURATE_EN
        // Saturation at both ends
        add(0, 0, 1, 1, 4'd8, 8, 0, 0);
        add(0, 1, 1, 0, 0, 9, 0, 0);
        add(0, 1, 1, 0, 0, 9, 0, 0);
        add(0, 1, 1, 0, 0, 9, 0, 0);
        add(0, 0, 0, 1, 4'd1, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);
`endif

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].up, tbl[i].load, tbl[i].d);
            chk($sformatf("vec%0d.Q", i), int'(bus.Q), tbl[i].q);
            chk($sformatf("vec%0d.WRAP", i), int'(bus.WRAP), tbl[i].wrap);
            chk($sformatf("vec%0d.LOAD_ERR", i), int'(bus.LOAD_ERR), tbl[i].lerr);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic r, e, u, l;
            logic [3:0] dv;
            r  = ($urandom_range(0, 39) == 0);
            e  = ($urandom_range(0, 3) != 0);
            u  = $urandom_range(0, 1);
            l  = ($urandom_range(0, 7) == 0);
            dv = 4'($urandom_range(0, 15));
            step(r, e, u, l, dv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jk_counter_ctrl.md
Name: jk_counter_ctrl

Overview:
- Synchronous modulo up/down counter whose state bits are held in a row of JK storage cells.
- The block computes the J/K excitation for each bit, drives it into the cells, and exposes both the excitation vectors and the count.
- It is the stage that directly feeds JK flip-flops: the control/excitation logic wrapped around a bank of them.
- Used as the sequencing counter for the project's datapath and display logic.

Parameters:
- WIDTH, 4, number of state bits / JK cells.
- MODULUS, 10, count range 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH; elaboration fails outside this range.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous reset, active-high.
- EN  in  1  count enable.
- UP  in  1  direction: 1 = increment, 0 = decrement.
- LOAD  in  1  synchronous parallel load.
- D  in  WIDTH  load value.
- Q  out  WIDTH  current count (registered).
- J  out  WIDTH  J excitation currently applied to each cell (combinational).
- K  out  WIDTH  K excitation currently applied to each cell (combinational).
- TC  out  1  terminal count (combinational).
- WRAP  out  1  one-cycle pulse (registered) in the cycle after a wrap.
- LOAD_ERR  out  1  one-cycle pulse (registered) in the cycle after an out-of-range load.

Behaviour:
Reset:
- One clock, one reset; reset is synchronous and active-high.
- Ports are named CLK and RST.
- RST=1 at a posedge forces Q=0, WRAP=0 and LOAD_ERR=0, regardless of EN/LOAD.
- RST asserted mid-count wins over everything; counting resumes from 0 on the first posedge after RST deasserts (when EN=1).

Priority and next state N:
- Order per posedge: RST > LOAD > EN > hold.
- LOAD=1: N = D if D < MODULUS; otherwise N = MODULUS-1 and LOAD_ERR=1 on the next cycle.
- EN=1, UP=1: N = Q+1, or 0 if Q == MODULUS-1 (wrap).
- EN=1, UP=0: N = Q-1, or MODULUS-1 if Q == 0 (wrap).
- EN=0 and LOAD=0: N = Q.

Excitation (toggle form):
- J[i] = K[i] = N[i] ^ Q[i]. Unchanged bits get JK=00 (hold); changing bits get 11 (toggle).
- During RST, J[i] = K[i] = Q[i], so set bits toggle to 0 and clear bits hold.
- J/K are combinational from Q and the inputs; Q updates one posedge later (latency 1).

Cells:
- Each cell implements JK semantics: 00 hold, 01 clear, 10 set, 11 toggle.
- Each cell has a synchronous reset to 0.

TC:
- TC = EN & ~LOAD & (UP ? Q == MODULUS-1 : Q == 0).
- TC is low while RST=1.

WRAP:
- WRAP is registered: it equals 1 in the cycle after a posedge where TC=1 and the count wrapped.
- Cleared on the next posedge unless another wrap occurs.

Other rules:
- Q must never leave 0..MODULUS-1, including after any LOAD.
- A direction change takes effect on the same edge it is sampled.
- LOAD and EN both high: the load wins and no WRAP is generated.

Optional Feature:
- Macro: JK_CNT_SATURATE_EN.
- When defined: the counter saturates instead of wrapping. At Q == MODULUS-1 with UP=1, or Q == 0 with UP=0, N = Q, so J = K = 0 for all bits. TC still asserts; WRAP is tied to 0.
- When undefined: wrap behaviour as above.

Decomposition:
- Shared package jk_cnt_pkg:
  - JK code constants: JK_HOLD=2'b00, JK_CLR=2'b01, JK_SET=2'b10, JK_TGL=2'b11.
  - Default WIDTH/MODULUS localparams.
  - A function returning the toggle-form excitation for (cur, nxt).
- Sub-module jk_cell: one JK storage bit with CLK, RST (sync, active-high), J, K, Q. It is instantiated WIDTH times via generate.
- The next-state, TC, WRAP and LOAD_ERR logic stays in the top module.

Test Plan (WIDTH=4, MODULUS=10 unless noted):
- Reset: RST=1 for 2 cycles while EN=1, UP=1 -> Q=0, WRAP=0, LOAD_ERR=0; then 12 cycles EN=1 -> Q goes 1..9, 0, 1, 2; WRAP=1 exactly once, in the cycle after Q 9->0.
- Down wrap: load D=0, then EN=1, UP=0 -> Q goes 9, 8, 7; TC=1 only while Q=0; J=K=4'b1001 on the 0->9 edge.
- Bad load: LOAD=1, D=4'd13 -> Q=9 next cycle, LOAD_ERR=1 for exactly one cycle; LOAD=1 with D=5 and EN=1 in the same cycle -> Q=5, no WRAP.
- Excitation check: Q=7, UP=1, EN=1 -> J=K=4'b1111 and Q=8 next cycle; EN=0 -> J=K=0 and Q held for 5 cycles.
- Reset mid-count: at Q=6, assert RST for 1 cycle with EN=1 -> Q=0 the next cycle; counting resumes 1, 2, … once RST=0.
- With JK_CNT_SATURATE_EN defined: UP=1 from Q=8 -> Q goes 9, 9, 9 with J=K=0 and WRAP stays 0; UP=0 from Q=1 -> Q goes 0, 0.
